// File: rtl/ptw_filter_pkg.sv
// Shared types and sizing for the PTW request filter and its age matrix.
package ptw_filter_pkg;
  localparam int VPN_W   = 27;
  localparam int SRC_W   = 2;
  localparam int SRC_NUM = 1 << SRC_W;
  localparam int ENTRIES = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ISSUED = 2'd2
  } entry_state_e;

  function automatic logic [SRC_NUM-1:0] src_onehot(input logic [SRC_W-1:0] src);
    src_onehot = SRC_NUM'(1) << src;
  endfunction
endpackage

// File: rtl/ptw_filter_age.sv
// Age matrix over the pending slots: reports the oldest candidate by allocation order.
module ptw_filter_age
  import ptw_filter_pkg::*;
#(
  parameter int N = ENTRIES
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] alloc,
  input  logic [N-1:0] cand,
  output logic [N-1:0] oldest
);

  // age[i][j] set means slot i was allocated before slot j
  logic [N-1:0][N-1:0] age;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      age <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (alloc[i]) age[i] <= '0;
        else          age[i] <= age[i] | alloc;
      end
    end
  end

  always_comb begin
    oldest = '0;
    for (int i = 0; i < N; i++) begin
      oldest[i] = cand[i];
      for (int j = 0; j < N; j++) begin
        if (j != i && cand[j] && !age[i][j]) oldest[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ptw_req_filter.sv
// Buffers arbitrated translation requests, merges same-vpn requesters into one walk,
// keeps at most one walk in flight and broadcasts completion with a waiter mask.
module ptw_req_filter
  import ptw_filter_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               io_flush,
  input  logic               io_in_valid,
  output logic               io_in_ready,
  input  logic [VPN_W-1:0]   io_in_bits_vpn,
  input  logic [SRC_W-1:0]   io_in_bits_source,
  output logic               io_ptw_req_valid,
  input  logic               io_ptw_req_ready,
  output logic [VPN_W-1:0]   io_ptw_req_bits_vpn,
  input  logic               io_ptw_resp_valid,
  output logic               io_resp_valid,
  output logic [VPN_W-1:0]   io_resp_bits_vpn,
  output logic [SRC_NUM-1:0] io_resp_bits_srcmask
);

  entry_state_e       state_q [ENTRIES];
  entry_state_e       state_d [ENTRIES];
  logic [VPN_W-1:0]   vpn_q   [ENTRIES];
  logic [VPN_W-1:0]   vpn_d   [ENTRIES];
  logic [SRC_NUM-1:0] mask_q  [ENTRIES];
  logic [SRC_NUM-1:0] mask_d  [ENTRIES];
  logic               drop_q, drop_d;

  logic               resp_vld_p1;
  logic [VPN_W-1:0]   resp_vpn_p1;
  logic [SRC_NUM-1:0] resp_mask_p1;

  logic [ENTRIES-1:0] idle_vec, wait_vec, issued_vec, match_vec, free_vec, alloc_vec, oldest;
  logic [SRC_NUM-1:0] src_bit, done_mask;
  logic [VPN_W-1:0]   req_vpn, done_vpn;
  logic               match, accept, outstanding, req_fire, resp_hit;

  always_comb begin
    idle_vec   = '0;
    wait_vec   = '0;
    issued_vec = '0;
    match_vec  = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      idle_vec[i]   = (state_q[i] == ST_IDLE);
      wait_vec[i]   = (state_q[i] == ST_WAIT);
      issued_vec[i] = (state_q[i] == ST_ISSUED);
      match_vec[i]  = (state_q[i] != ST_IDLE) && (vpn_q[i] == io_in_bits_vpn);
    end
  end

  // lowest set bit of the idle vector
  assign free_vec    = idle_vec & (-idle_vec);
  assign match       = |match_vec;
  assign src_bit     = src_onehot(io_in_bits_source);
  assign io_in_ready = !io_flush && (match || (|idle_vec));
  assign accept      = io_in_valid && io_in_ready;
  assign alloc_vec   = (accept && !match) ? free_vec : '0;

  assign outstanding      = (|issued_vec) || drop_q;
  assign io_ptw_req_valid = !outstanding && (|wait_vec) && !io_flush;
  assign req_fire         = io_ptw_req_valid && io_ptw_req_ready;
  assign resp_hit         = io_ptw_resp_valid && !drop_q && (|issued_vec);

  ptw_filter_age #(.N(ENTRIES)) u_age (
    .clock  (clock),
    .reset  (reset),
    .alloc  (alloc_vec),
    .cand   (wait_vec),
    .oldest (oldest)
  );

  // a same-cycle merge into the completing walk joins its broadcast
  always_comb begin
    req_vpn   = '0;
    done_vpn  = '0;
    done_mask = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (oldest[i]) req_vpn |= vpn_q[i];
      if (issued_vec[i]) begin
        done_vpn  |= vpn_q[i];
        done_mask |= mask_q[i] | ((accept && match_vec[i]) ? src_bit : '0);
      end
    end
  end

  assign io_ptw_req_bits_vpn = req_vpn;

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      state_d[i] = state_q[i];
      vpn_d[i]   = vpn_q[i];
      mask_d[i]  = mask_q[i];
      if (io_flush) begin
        state_d[i] = ST_IDLE;
      end else begin
        if (resp_hit && issued_vec[i]) state_d[i] = ST_IDLE;
        if (req_fire && oldest[i])     state_d[i] = ST_ISSUED;
        if (alloc_vec[i]) begin
          state_d[i] = ST_WAIT;
          vpn_d[i]   = io_in_bits_vpn;
          mask_d[i]  = src_bit;
        end else if (accept && match_vec[i]) begin
          mask_d[i] = mask_q[i] | src_bit;
        end
      end
    end
    // a response landing with the flush retires the dropped walk at once
    if (io_flush)                            drop_d = ((|issued_vec) || drop_q) && !io_ptw_resp_valid;
    else if (io_ptw_resp_valid && drop_q)    drop_d = 1'b0;
    else                                     drop_d = drop_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        state_q[i] <= ST_IDLE;
        mask_q[i]  <= '0;
      end
      drop_q       <= 1'b0;
      resp_vld_p1  <= 1'b0;
      resp_vpn_p1  <= '0;
      resp_mask_p1 <= '0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      drop_q      <= drop_d;
      resp_vld_p1 <= resp_hit && !io_flush;
      if (resp_hit && !io_flush) begin
        resp_vpn_p1  <= done_vpn;
        resp_mask_p1 <= done_mask;
      end
    end
  end

  always_ff @(posedge clock) begin
    vpn_q <= vpn_d;
  end

  assign io_resp_valid        = resp_vld_p1;
  assign io_resp_bits_vpn     = resp_vpn_p1;
  assign io_resp_bits_srcmask = resp_mask_p1;

endmodule

// File: tb/tb_ptw_req_filter.sv
// Directed bench for ptw_req_filter: per-cycle vector table plus an async-reset sequence.
module tb_ptw_req_filter;
  import ptw_filter_pkg::*;

  logic               clock;
  logic               reset;
  logic               io_flush;
  logic               io_in_valid;
  logic               io_in_ready;
  logic [VPN_W-1:0]   io_in_bits_vpn;
  logic [SRC_W-1:0]   io_in_bits_source;
  logic               io_ptw_req_valid;
  logic               io_ptw_req_ready;
  logic [VPN_W-1:0]   io_ptw_req_bits_vpn;
  logic               io_ptw_resp_valid;
  logic               io_resp_valid;
  logic [VPN_W-1:0]   io_resp_bits_vpn;
  logic [SRC_NUM-1:0] io_resp_bits_srcmask;

  ptw_req_filter dut (
    .clock                (clock),
    .reset                (reset),
    .io_flush             (io_flush),
    .io_in_valid          (io_in_valid),
    .io_in_ready          (io_in_ready),
    .io_in_bits_vpn       (io_in_bits_vpn),
    .io_in_bits_source    (io_in_bits_source),
    .io_ptw_req_valid     (io_ptw_req_valid),
    .io_ptw_req_ready     (io_ptw_req_ready),
    .io_ptw_req_bits_vpn  (io_ptw_req_bits_vpn),
    .io_ptw_resp_valid    (io_ptw_resp_valid),
    .io_resp_valid        (io_resp_valid),
    .io_resp_bits_vpn     (io_resp_bits_vpn),
    .io_resp_bits_srcmask (io_resp_bits_srcmask)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic               fl, iv;
    logic [VPN_W-1:0]   vpn;
    logic [SRC_W-1:0]   src;
    logic               rr, pr;
    logic               e_rdy, e_req;
    logic [VPN_W-1:0]   e_req_vpn;
    logic               e_rsp;
    logic [VPN_W-1:0]   e_rsp_vpn;
    logic [SRC_NUM-1:0] e_mask;
  } vec_t;

  vec_t vecs[$];
  int   n_applied = 0;
  int   n_miss    = 0;

  task automatic add(input int fl, iv, vpn, src, rr, pr, er, eq, eqv, es, esv, em);
    vec_t v;
    v.fl = (fl != 0);  v.iv = (iv != 0);
    v.vpn = VPN_W'(vpn);  v.src = SRC_W'(src);
    v.rr = (rr != 0);  v.pr = (pr != 0);
    v.e_rdy = (er != 0);  v.e_req = (eq != 0);  v.e_req_vpn = VPN_W'(eqv);
    v.e_rsp = (es != 0);  v.e_rsp_vpn = VPN_W'(esv);  v.e_mask = SRC_NUM'(em);
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".in_ready"},  32'(io_in_ready), 32'd1);
    chk({tag, ".req_valid"}, 32'(io_ptw_req_valid), 32'd0);
    chk({tag, ".req_vpn"},   32'(io_ptw_req_bits_vpn), 32'd0);
    chk({tag, ".resp_valid"},32'(io_resp_valid), 32'd0);
    chk({tag, ".resp_vpn"},  32'(io_resp_bits_vpn), 32'd0);
    chk({tag, ".resp_mask"}, 32'(io_resp_bits_srcmask), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    io_flush = 1'b0; io_in_valid = 1'b0; io_in_bits_vpn = '0; io_in_bits_source = '0;
    io_ptw_req_ready = 1'b0; io_ptw_resp_valid = 1'b0;

    // fl iv vpn src rr pr | rdy req req_vpn | rsp rsp_vpn mask
    // single walk
    add(0,1,'h1234,1,0,0, 1,0,0,       0,0,0);
    add(0,0,0,0,1,0,      1,1,'h1234,  0,0,0);
    add(0,0,0,0,1,0,      1,0,0,       0,0,0);
    add(0,0,0,0,0,0,      1,0,0,       0,0,0);
    add(0,0,0,0,0,0,      1,0,0,       0,0,0);
    add(0,0,0,0,0,1,      1,0,0,       0,0,0);
    add(0,0,0,0,0,0,      1,0,0,       1,'h1234,'b0010);
    add(0,0,0,0,0,0,      1,0,0,       0,0,0);
    // merge, including a merge coinciding with completion
    add(0,1,'hA,0,1,0,    1,0,0,       0,0,0);
    add(0,1,'hA,3,1,0,    1,1,'hA,     0,0,0);
    add(0,0,0,0,1,0,      1,0,0,       0,0,0);
    add(0,1,'hA,2,1,1,    1,0,0,       0,0,0);
    add(0,0,0,0,1,0,      1,0,0,       1,'hA,'b1101);
    add(0,0,0,0,1,0,      1,0,0,       0,0,0);
    // full / backpressure, then drain in age order
    add(0,1,'h10,0,0,0,   1,0,0,       0,0,0);
    add(0,1,'h11,1,0,0,   1,1,'h10,    0,0,0);
    add(0,1,'h12,2,0,0,   1,1,'h10,    0,0,0);
    add(0,1,'h13,3,0,0,   1,1,'h10,    0,0,0);
    add(0,1,'h14,0,0,0,   0,1,'h10,    0,0,0);
    add(0,1,'h12,1,0,0,   1,1,'h10,    0,0,0);
    add(0,1,'h14,0,1,0,   0,1,'h10,    0,0,0);
    add(0,1,'h14,0,1,0,   0,0,0,       0,0,0);
    add(0,1,'h14,0,0,1,   0,0,0,       0,0,0);
    add(0,1,'h14,0,0,0,   1,1,'h11,    1,'h10,'b0001);
    add(0,0,0,0,1,0,      0,1,'h11,    0,0,0);
    add(0,0,0,0,1,1,      0,0,0,       0,0,0);
    add(0,0,0,0,1,0,      1,1,'h12,    1,'h11,'b0010);
    add(0,0,0,0,1,1,      1,0,0,       0,0,0);
    add(0,0,0,0,1,0,      1,1,'h13,    1,'h12,'b0110);
    add(0,0,0,0,1,1,      1,0,0,       0,0,0);
    add(0,0,0,0,1,0,      1,1,'h14,    1,'h13,'b1000);
    add(0,0,0,0,1,1,      1,0,0,       0,0,0);
    add(0,0,0,0,0,0,      1,0,0,       1,'h14,'b0001);
    // ordering with a stalled then released walker
    add(0,1,'h1,0,0,0,    1,0,0,       0,0,0);
    add(0,1,'h2,1,0,0,    1,1,'h1,     0,0,0);
    add(0,1,'h3,2,0,0,    1,1,'h1,     0,0,0);
    add(0,0,0,0,1,0,      1,1,'h1,     0,0,0);
    add(0,0,0,0,1,0,      1,0,0,       0,0,0);
    add(0,0,0,0,1,1,      1,0,0,       0,0,0);
    add(0,0,0,0,1,0,      1,1,'h2,     1,'h1,'b0001);
    add(0,0,0,0,1,0,      1,0,0,       0,0,0);
    add(0,0,0,0,1,1,      1,0,0,       0,0,0);
    add(0,0,0,0,1,0,      1,1,'h3,     1,'h2,'b0010);
    add(0,0,0,0,1,1,      1,0,0,       0,0,0);
    add(0,0,0,0,0,0,      1,0,0,       1,'h3,'b0100);
    // flush mid-walk: later resp is swallowed and gates the next issue
    add(0,1,'h55,0,1,0,   1,0,0,       0,0,0);
    add(0,1,'h66,1,1,0,   1,1,'h55,    0,0,0);
    add(0,0,0,0,1,0,      1,0,0,       0,0,0);
    add(1,1,'h77,2,1,0,   0,0,0,       0,0,0);
    add(0,1,'h77,2,1,0,   1,0,0,       0,0,0);
    add(0,0,0,0,1,0,      1,0,0,       0,0,0);
    add(0,0,0,0,1,1,      1,0,0,       0,0,0);
    add(0,0,0,0,1,0,      1,1,'h77,    0,0,0);
    add(0,0,0,0,0,1,      1,0,0,       0,0,0);
    add(0,0,0,0,0,0,      1,0,0,       1,'h77,'b0100);
    // flush coinciding with the response consumes it
    add(0,1,'h88,3,1,0,   1,0,0,       0,0,0);
    add(0,0,0,0,1,0,      1,1,'h88,    0,0,0);
    add(1,0,0,0,1,1,      0,0,0,       0,0,0);
    add(0,1,'h99,1,1,0,   1,0,0,       0,0,0);
    add(0,0,0,0,1,0,      1,1,'h99,    0,0,0);
    add(0,0,0,0,0,1,      1,0,0,       0,0,0);
    add(0,0,0,0,0,0,      1,0,0,       1,'h99,'b0010);

    repeat (2) @(posedge clock);
    #1;
    chk_reset_outputs("reset");
    reset = 1'b0;
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      io_flush          = vecs[i].fl;
      io_in_valid       = vecs[i].iv;
      io_in_bits_vpn    = vecs[i].vpn;
      io_in_bits_source = vecs[i].src;
      io_ptw_req_ready  = vecs[i].rr;
      io_ptw_resp_valid = vecs[i].pr;
      #2;
      chk($sformatf("v%0d.in_ready", i),   32'(io_in_ready),      32'(vecs[i].e_rdy));
      chk($sformatf("v%0d.req_valid", i),  32'(io_ptw_req_valid), 32'(vecs[i].e_req));
      if (vecs[i].e_req)
        chk($sformatf("v%0d.req_vpn", i),  32'(io_ptw_req_bits_vpn), 32'(vecs[i].e_req_vpn));
      chk($sformatf("v%0d.resp_valid", i), 32'(io_resp_valid),    32'(vecs[i].e_rsp));
      if (vecs[i].e_rsp) begin
        chk($sformatf("v%0d.resp_vpn", i),  32'(io_resp_bits_vpn),     32'(vecs[i].e_rsp_vpn));
        chk($sformatf("v%0d.resp_mask", i), 32'(io_resp_bits_srcmask), 32'(vecs[i].e_mask));
      end
      step();
    end

    // async reset mid-walk while a response is being broadcast
    io_flush = 1'b0; io_ptw_resp_valid = 1'b0;
    io_in_valid = 1'b1; io_in_bits_vpn = 'h42; io_in_bits_source = 2'd0; io_ptw_req_ready = 1'b0;
    step();
    io_in_bits_vpn = 'h43; io_in_bits_source = 2'd1; io_ptw_req_ready = 1'b1;
    step();
    io_in_valid = 1'b0; io_in_bits_vpn = '0; io_ptw_req_ready = 1'b0; io_ptw_resp_valid = 1'b1;
    step();
    io_ptw_resp_valid = 1'b0;
    #1;
    chk("prereset.resp_valid", 32'(io_resp_valid), 32'd1);
    chk("prereset.resp_vpn",   32'(io_resp_bits_vpn), 32'h42);
    chk("prereset.req_valid",  32'(io_ptw_req_valid), 32'd1);
    chk("prereset.req_vpn",    32'(io_ptw_req_bits_vpn), 32'h43);
    reset = 1'b1;
    #1;
    chk_reset_outputs("async_reset");
    #2;
    reset = 1'b0;
    io_ptw_resp_valid = 1'b1;
    step();
    io_ptw_resp_valid = 1'b0;
    #1;
    chk("stray.resp_valid", 32'(io_resp_valid), 32'd0);
    chk("stray.req_valid",  32'(io_ptw_req_valid), 32'd0);
    chk("stray.in_ready",   32'(io_in_ready), 32'd1);
    step();
    chk("stray2.resp_valid", 32'(io_resp_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end

endmodule
